// File: rtl/ncpu32k_cdb_arbiter.sv
// rtl/ncpu32k_cdb_arbiter.sv - commit data bus arbiter selecting one FU commit packet per cycle toward the ROB
//
// Purpose: picks one of WAYS functional-unit commit ports and forwards its
//   packet (data, tag, id) combinationally to the reorder buffer. The search
//   order starts at a pointer that advances past the winner on each handshake
//   (round-robin), or always starts at way 0 (fixed priority).
//
// Configuration macro: NCPU_CDB_ROUND_ROBIN_EN
//   defined   -> round-robin, pointer register present
//   undefined -> fixed priority, lowest valid way wins, no state at all
//
// Ports:
//   clk                in   clock, rising edge
//   rst_n              in   synchronous reset, active HIGH
//   fu_commit_BVALID   in   [WAYS]            per-FU packet valid
//   fu_commit_BREADY   out  [WAYS]            per-FU accept (one-hot or zero)
//   fu_commit_BDATA    in   [WAYS*DW]         packed data, way i at [i*DW +: DW]
//   fu_commit_BTAG     in   [WAYS*TAG_WIDTH]  packed tags
//   fu_commit_id       in   [WAYS*ID_WIDTH]   packed ids
//   rob_commit_BVALID  out  any FU valid
//   rob_commit_BREADY  in   ROB accept
//   rob_commit_BDATA   out  [DW]              granted data, zero when idle
//   rob_commit_BTAG    out  [TAG_WIDTH]       granted tag, zero when idle
//   rob_commit_id      out  [ID_WIDTH]        granted id, zero when idle

`ifndef NCPU_DW
`define NCPU_DW 32
`endif

module ncpu32k_cdb_arbiter #(
  parameter int WAYS      = 4,
  parameter int TAG_WIDTH = 4,
  parameter int ID_WIDTH  = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [WAYS-1:0]               fu_commit_BVALID,
  output logic [WAYS-1:0]               fu_commit_BREADY,
  input  logic [WAYS*`NCPU_DW-1:0]      fu_commit_BDATA,
  input  logic [WAYS*TAG_WIDTH-1:0]     fu_commit_BTAG,
  input  logic [WAYS*ID_WIDTH-1:0]      fu_commit_id,
  output logic                          rob_commit_BVALID,
  input  logic                          rob_commit_BREADY,
  output logic [`NCPU_DW-1:0]           rob_commit_BDATA,
  output logic [TAG_WIDTH-1:0]          rob_commit_BTAG,
  output logic [ID_WIDTH-1:0]           rob_commit_id
);

  localparam int DW    = `NCPU_DW;
  localparam int PTR_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  logic [PTR_W-1:0] w_ptr;
  logic [WAYS-1:0]  w_grant;
  logic [PTR_W-1:0] w_grant_idx;
  logic             w_grant_any;
  logic [PTR_W:0]   w_probe;
  logic             w_handshake;

  assign w_handshake = w_grant_any & rob_commit_BREADY;

`ifdef NCPU_CDB_ROUND_ROBIN_EN
  logic [PTR_W-1:0] r_ptr;

  // The pointer moves just past the accepted way so that way gets the lowest
  // priority next time; a stalled ROB leaves it (and thus the grant) alone.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_ptr <= '0;
    end else if (w_handshake) begin
      r_ptr <= (w_grant_idx == PTR_W'(WAYS - 1)) ? '0 : w_grant_idx + PTR_W'(1);
    end
  end

  assign w_ptr = r_ptr;
`else
  // Fixed priority: the search always begins at way 0 and nothing is stored,
  // so clock, reset and the handshake have no effect on this build.
  logic w_unused_fixed;
  assign w_ptr          = '0;
  assign w_unused_fixed = clk ^ rst_n ^ w_handshake ^ (^w_grant_idx);
`endif

  // Rotating search: probe = (ptr + k) mod WAYS for k = 0..WAYS-1, first valid
  // wins. ptr + k is at most 2*WAYS-2, so one subtraction brings it in range.
  always_comb begin
    w_grant     = '0;
    w_grant_idx = '0;
    w_grant_any = 1'b0;
    w_probe     = '0;
    for (int k = 0; k < WAYS; k++) begin
      w_probe = {1'b0, w_ptr} + (PTR_W + 1)'(k);
      if (w_probe >= (PTR_W + 1)'(WAYS)) begin
        w_probe = w_probe - (PTR_W + 1)'(WAYS);
      end
      if (!w_grant_any && fu_commit_BVALID[w_probe[PTR_W-1:0]]) begin
        w_grant[w_probe[PTR_W-1:0]] = 1'b1;
        w_grant_idx                 = w_probe[PTR_W-1:0];
        w_grant_any                 = 1'b1;
      end
    end
  end

  // AND-OR mux on the one-hot grant; an empty grant yields all zeros.
  always_comb begin
    rob_commit_BDATA = '0;
    rob_commit_BTAG  = '0;
    rob_commit_id    = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (w_grant[i]) begin
        rob_commit_BDATA = rob_commit_BDATA | fu_commit_BDATA[i*DW +: DW];
        rob_commit_BTAG  = rob_commit_BTAG  | fu_commit_BTAG[i*TAG_WIDTH +: TAG_WIDTH];
        rob_commit_id    = rob_commit_id    | fu_commit_id[i*ID_WIDTH +: ID_WIDTH];
      end
    end
  end

  assign rob_commit_BVALID = |fu_commit_BVALID;
  assign fu_commit_BREADY  = w_grant & {WAYS{rob_commit_BREADY}};

endmodule

// File: tb/tb_ncpu32k_cdb_arbiter.sv
// tb/tb_ncpu32k_cdb_arbiter.sv - self-checking bench for ncpu32k_cdb_arbiter

module tb_ncpu32k_cdb_arbiter;

  localparam int WAYS = 4;
  localparam int TW   = 4;
  localparam int IW   = 2;
  localparam int DW   = 32;

  logic                 clk;
  logic                 rst_n;
  logic [WAYS-1:0]      fu_valid;
  logic [WAYS-1:0]      fu_ready;
  logic [WAYS*DW-1:0]   fu_data;
  logic [WAYS*TW-1:0]   fu_tag;
  logic [WAYS*IW-1:0]   fu_id;
  logic                 rob_valid;
  logic                 rob_ready;
  logic [DW-1:0]        rob_data;
  logic [TW-1:0]        rob_tag;
  logic [IW-1:0]        rob_id;

  logic [DW-1:0] pay_data [WAYS];
  logic [TW-1:0] pay_tag  [WAYS];
  logic [IW-1:0] pay_id   [WAYS];

  int total = 0;
  int bad   = 0;
  int ptr_m = 0;

  ncpu32k_cdb_arbiter #(.WAYS(WAYS), .TAG_WIDTH(TW), .ID_WIDTH(IW)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .fu_commit_BVALID  (fu_valid),
    .fu_commit_BREADY  (fu_ready),
    .fu_commit_BDATA   (fu_data),
    .fu_commit_BTAG    (fu_tag),
    .fu_commit_id      (fu_id),
    .rob_commit_BVALID (rob_valid),
    .rob_commit_BREADY (rob_ready),
    .rob_commit_BDATA  (rob_data),
    .rob_commit_BTAG   (rob_tag),
    .rob_commit_id     (rob_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    fu_data = '0;
    fu_tag  = '0;
    fu_id   = '0;
    for (int w = 0; w < WAYS; w++) begin
      fu_data[w*DW +: DW] = pay_data[w];
      fu_tag[w*TW +: TW]  = pay_tag[w];
      fu_id[w*IW +: IW]   = pay_id[w];
    end
  end

  // Reference: which way wins, given the valid set and the search start.
`ifdef NCPU_CDB_ROUND_ROBIN_EN
  function automatic int model_grant(input logic [WAYS-1:0] vv);
    for (int k = 0; k < WAYS; k++) begin
      if (vv[(ptr_m + k) % WAYS]) return (ptr_m + k) % WAYS;
    end
    return -1;
  endfunction
`else
  function automatic int model_grant(input logic [WAYS-1:0] vv);
    for (int k = 0; k < WAYS; k++) begin
      if (vv[k]) return k;
    end
    return -1;
  endfunction
`endif

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive at the falling edge, check 1ns later, then let the rising
  // edge happen and advance the model. dir >= -1 adds a directed check of the
  // FU ready vector (-1 meaning none granted); dir = -2 skips it.
  task automatic step(input logic rs, input logic [WAYS-1:0] vv, input logic rdy,
                      input int dir, input string tag, output int hs);
    int               g;
    logic [WAYS-1:0]  e_ready;
    logic [DW-1:0]    e_data;
    logic [TW-1:0]    e_tag;
    logic [IW-1:0]    e_id;
    rst_n     = rs;
    fu_valid  = vv;
    rob_ready = rdy;
    #1;
    g       = model_grant(vv);
    e_ready = '0;
    e_data  = '0;
    e_tag   = '0;
    e_id    = '0;
    if (g >= 0) begin
      e_data = pay_data[g];
      e_tag  = pay_tag[g];
      e_id   = pay_id[g];
      if (rdy) e_ready[g] = 1'b1;
    end
    chk({tag, ".bvalid"}, 64'(rob_valid), 64'(|vv));
    chk({tag, ".bready"}, 64'(fu_ready),  64'(e_ready));
    chk({tag, ".data"},   64'(rob_data),  64'(e_data));
    chk({tag, ".tag"},    64'(rob_tag),   64'(e_tag));
    chk({tag, ".id"},     64'(rob_id),    64'(e_id));
    if (dir >= -1) begin
      chk({tag, ".dir"}, 64'(fu_ready), (dir >= 0) ? (64'd1 << dir) : 64'd0);
    end
    hs = (g >= 0 && rdy) ? g : -1;
    if (rs) ptr_m = 0;
    else if (hs >= 0) ptr_m = (hs + 1) % WAYS;
    @(negedge clk);
  endtask

  initial begin
    int hs;
    logic [WAYS-1:0] v;
    int fair [5];
    rst_n     = 1'b1;
    fu_valid  = '0;
    rob_ready = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      pay_data[w] = '0;
      pay_tag[w]  = '0;
      pay_id[w]   = '0;
    end
    repeat (2) @(negedge clk);

    // Idle while in reset
    step(1'b1, 4'b0000, 1'b0, -1, "reset_idle", hs);

    // Stall, first grant, second grant
    pay_data[0] = 32'h0badbeef; pay_tag[0] = 4'd1; pay_id[0] = 2'd0;
    pay_data[2] = 32'h00741235; pay_tag[2] = 4'd3; pay_id[2] = 2'd2;
    step(1'b0, 4'b0101, 1'b0, -1, "stall", hs);
    step(1'b0, 4'b0101, 1'b1,  0, "first", hs);
    pay_data[3] = 32'h00333333; pay_tag[3] = 4'd4; pay_id[3] = 2'd3;
    step(1'b0, 4'b1100, 1'b1,  2, "second_a", hs);
    step(1'b0, 4'b1000, 1'b1,  3, "second_b", hs);

    // Idle outside reset
    step(1'b0, 4'b0000, 1'b1, -1, "idle", hs);

    // Fairness / fixed priority with every way valid
`ifdef NCPU_CDB_ROUND_ROBIN_EN
    fair = '{0, 1, 2, 3, 0};
`else
    fair = '{0, 0, 0, 0, 0};
`endif
    step(1'b1, 4'b0000, 1'b0, -1, "pre_fair_rst", hs);
    for (int n = 0; n < 5; n++) begin
      pay_data[n % WAYS] = $urandom;
      step(1'b0, 4'b1111, 1'b1, fair[n], "fair", hs);
    end

    // Reset after grants 0 and 1: next grant goes to the lowest valid way
    step(1'b1, 4'b0000, 1'b0, -1, "pre_mid_rst", hs);
    step(1'b0, 4'b1111, 1'b1, -2, "g0", hs);
    step(1'b0, 4'b1111, 1'b1, -2, "g1", hs);
    step(1'b1, 4'b1111, 1'b0, -1, "mid_rst", hs);
    step(1'b0, 4'b0110, 1'b1,  1, "post_rst", hs);

    // Randomized traffic; a valid FU holds its payload until accepted
    v  = '0;
    hs = -1;
    for (int n = 0; n < 400; n++) begin
      logic rs;
      for (int w = 0; w < WAYS; w++) begin
        if (!v[w] || hs == w) begin
          v[w]        = 1'($urandom_range(0, 1));
          pay_data[w] = $urandom;
          pay_tag[w]  = TW'($urandom);
          pay_id[w]   = IW'($urandom);
        end
      end
      rs = ($urandom_range(0, 39) == 0);
      step(rs, v, ($urandom_range(0, 3) != 0), -2, "rand", hs);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ncpu32k_cdb_arbiter.md
NCPU32K_CDB_ARBITER -- requirements
Module: ncpu32k_cdb_arbiter

Interface
REQ-001 Parameters, one per line: name, default, meaning:
- WAYS, 4, number of functional-unit (FU) commit ports.
- TAG_WIDTH, 4, width of each B-packet tag.
- ID_WIDTH, 2, width of each commit id.
- Data width DW is `NCPU_DW (32) from ncpu32k_config.h; it is not a parameter.

REQ-002 Ports, one per line: name, direction, width, meaning:
- clk, in, 1, single clock; all state updates on its rising edge.
- rst_n, in, 1, reset; synchronous, active-high (the name follows the codebase, the polarity is high).
- fu_commit_BVALID, in, WAYS, per-FU packet valid.
- fu_commit_BREADY, out, WAYS, per-FU accept.
- fu_commit_BDATA, in, WAYS*DW, packed data; way i occupies [(i+1)*DW-1 : i*DW].
- fu_commit_BTAG, in, WAYS*TAG_WIDTH, packed tags, same slicing.
- fu_commit_id, in, WAYS*ID_WIDTH, packed ids, same slicing.
- rob_commit_BVALID, out, 1, arbitrated packet valid toward the ROB.
- rob_commit_BREADY, in, 1, ROB accept.
- rob_commit_BDATA, out, DW, selected data.
- rob_commit_BTAG, out, TAG_WIDTH, selected tag.
- rob_commit_id, out, ID_WIDTH, selected id.

Function
REQ-003 A handshake occurs on any cycle where VALID & READY are both 1 at the rising edge of clk; this holds for the FU side and the ROB side.
REQ-004 The grant is combinational: exactly one FU is selected when at least one fu_commit_BVALID bit is set; no FU is selected otherwise.
REQ-005 The priority search starts at index ptr and proceeds ptr, ptr+1, ..., WAYS-1, 0, ..., ptr-1; the first valid way wins.
REQ-006 The outputs rob_commit_BDATA, rob_commit_BTAG and rob_commit_id are combinational muxes of the granted way's slices, with zero latency.
REQ-007 The data, tag and id outputs are all-zero when no FU is granted.
REQ-008 rob_commit_BVALID = |fu_commit_BVALID.
REQ-009 fu_commit_BREADY[i] = grant[i] & rob_commit_BREADY; at most one bit is set.
REQ-010 fu_commit_BREADY is all-zero while rob_commit_BREADY = 0, regardless of the valids.
REQ-011 On a handshake with way g, ptr <= (g+1) mod WAYS, wrapping from WAYS-1 to 0; otherwise ptr holds.
REQ-012 ptr changes only on a handshake, so the grant is stable while the valid set is stable and the ROB is stalled.
REQ-013 An FU that asserts VALID holds VALID and its payload until its handshake.
REQ-014 The valid set may change freely on any cycle; the grant follows combinationally.
REQ-015 Only one packet is transferred per cycle; ungranted FUs wait with BREADY = 0.
REQ-016 No FIFOs and no registered data path; ptr is the only state.

Reset
REQ-017 While rst_n = 1 at a rising edge of clk, ptr <= 0.
REQ-018 A reset asserted mid-stall discards no packet, because no payload is held internally; the grant restarts its search from way 0.
REQ-019 Outputs have no reset value of their own; with all valids at 0 they are: rob_commit_BVALID = 0, fu_commit_BREADY = 0, data/tag/id = 0.

Configuration
REQ-020 The arbitration policy is selected by the macro NCPU_CDB_ROUND_ROBIN_EN:
- Defined: round-robin per REQ-005 and REQ-011.
- Undefined: fixed priority, where the lowest valid index always wins; ptr is removed and is constant 0.
- The interface and timing are identical in both cases.

Verification
REQ-021 Directed scenarios the bench covers:
- Stall. Valid=0101, way0 {0x0badbeef, tag 1, id 0}, way2 {0x741235, tag 3, id 2}, rob ready=0 -> fu BREADY=0000 and rob_commit_BVALID=1.
- First grant. Same as Stall, then rob ready=1 -> fu BREADY=0001; outputs 0x0badbeef, tag 1, id 0.
- Second grant. Valid=1100, way3 {0x333333, tag 4, id 3}, ready=1 -> way2 granted: 0x741235, tag 3, id 2. Then valid=1000 -> way3 granted: 0x333333, tag 4, id 3, BREADY=1000.
- Fairness (round-robin). All ways valid, ready held 1 -> grants cycle 0,1,2,3,0 on consecutive cycles.
- Fixed priority (macro undefined). All ways valid -> way0 granted every cycle.
- Idle and reset. Valid=0000 -> rob_commit_BVALID=0 and outputs zero. Reset asserted after grants 0 and 1 -> ptr=0, next grant is the lowest valid way.
